k_wctl_t2: RTL and testbench
============================

# k_wctl_t2

Write-side control for the dual-clock FIFO. It keeps the write pointer as both a binary count and a Gray code, and produces the RAM write address and write enable. It synchronises the read pointer into the write clock domain and generates the registered full, almost-full and overflow flags. It pairs with the read-side control: its Gray `wptr` feeds the read domain's synchroniser, and it consumes the raw Gray read pointer `rptr` from the read domain.

## Interface
- `addr_size`, 4, address width; FIFO depth = 2^addr_size.
- `afull_thresh`, 2, `wafull` asserts when free slots ≤ `afull_thresh`; legal range 1 .. 2^addr_size−1.

Ports:
- `wclk`  in  1  write clock; the only clock in the block.
- `wrst`  in  1  reset, synchronous, active-high.
- `wput`  in  1  write request.
- `wrptr`  in  addr_size+1  Gray read pointer from the read domain, unsynchronised.
- `wen`  out  1  RAM write enable, combinational: `wput & ~wfull`.
- `waddr`  out  addr_size  RAM write address, equal to `wbin[addr_size-1:0]`.
- `wptr`  out  addr_size+1  registered Gray write pointer, sent to the read domain.
- `wfull`  out  1  registered full flag.
- `wafull`  out  1  registered almost-full flag; present only with the macro.
- `wovf`  out  1  sticky overflow flag.

## Operation
- **State registers:** `wbin`, `wptr` (addr_size+1 bits each), `wq1_rptr`, `wq2_rptr` (2-flop synchroniser), `wfull`, `wafull`, `wovf`.
- **Reset values:** every register above resets to 0, so `waddr`=0, `wptr`=0, `wfull`=0, `wafull`=0, `wovf`=0. `wen` then equals `wput`.
- **Accept rule:** a write is accepted when `wput=1` and `wfull=0`.
  - `wbinnext = wbin + accept`, modulo 2^(addr_size+1).
  - `wgraynext = wbinnext ^ (wbinnext >> 1)`.
- **Full:** `wfull_next` = (`wgraynext` == {~`wq2_rptr`[top two bits], `wq2_rptr`[remaining bits]}).
- **Overflow:** `wput=1` while `wfull=1` sets `wovf`. The write is dropped and the pointers hold. `wovf` clears only on `wrst`.
- **Wrap-around:** pointers wrap naturally modulo 2^(addr_size+1). The MSB distinguishes full from empty.
- **Synchroniser:** `wq1_rptr <= wrptr`, `wq2_rptr <= wq1_rptr`. No other logic samples `wrptr`.
- **Reset mid-operation:** `wrst` dominates. All state clears on that edge even with `wput=1`. Data already in the RAM is abandoned, and the read side must be reset together with this block.
- **Simultaneous events:** a write and a read-pointer change in the same cycle are independent. Full is evaluated using `wgraynext` and the current `wq2_rptr`.

## Timing
- **Accepted write:** `waddr`, `wptr` and `wfull` update on the same rising edge as the write. The write that fills the FIFO makes `wfull`=1 on that edge, so no further write is accepted the next cycle.
- **`wen`:** zero latency from `wput`.
- **Full release:** after `wrptr` changes, `wfull` deasserts on the 3rd `wclk` edge (two synchroniser edges plus one flag edge). This delay is pessimistic and safe.
- **`wptr` stability:** `wptr` changes by at most one bit per `wclk` cycle.

## Configuration
- **Macro:** `K_WCTL_AFULL_EN`.
- **Defined:**
  - `wq2_rptr` is converted Gray→binary into `wrbin`.
  - `wlevel = wbinnext − wrbin`, modulo 2^(addr_size+1).
  - `wafull` is registered as `wlevel ≥ 2^addr_size − afull_thresh`, with the same latency as `wfull`.
- **Not defined:** the `wafull` port, the Gray→binary converter and the level subtractor are absent. All other behaviour is identical.

## Test plan
All scenarios use `addr_size`=4 and `afull_thresh`=2.

- **Reset:** assert `wrst` 2 cycles, `wrptr`=0 → `wptr`=0, `waddr`=0, `wfull`=0, `wafull`=0, `wovf`=0.
- **Fill:** with `wrptr`=0, issue 16 back-to-back `wput` →
  - `waddr` steps 0..15 and `wptr` follows 0,1,3,2,6,…;
  - after the 16th edge, `wptr`=5'b11000, `wfull`=1, `wen`=0.
- **Overflow:** from full, hold `wput`=1 for 3 cycles → `wptr` stays 5'b11000, `wovf`=1 from the first edge, and `wovf` stays 1 until `wrst`.
- **Release and wrap:** from full, set `wrptr`=5'b00001 →
  - `wfull`=0 on the 3rd edge;
  - one write then goes to `waddr`=0 and gives `wptr`=gray(17)=5'b11001, `wfull`=1.
  - Continue until 32 total writes: `wptr` wraps to 0 with `wfull` correct throughout.
- **Almost full (macro defined):** with `wrptr`=0, after the 14th write `wafull`=1 and `wfull`=0. Then set `wrptr`=gray(1) → `wafull`=0 three edges later (level 13).
- **Reset mid-operation:** after 7 writes, assert `wrst` for 1 cycle with `wput`=1 → all outputs 0. The next write uses `waddr`=0 and gives `wptr`=5'b00001.

Source files
------------

// File: rtl/k_wctl_t2.sv
// k_wctl_t2: write-side pointer, RAM address/enable and full/overflow flags for a dual-clock FIFO.
// Define K_WCTL_AFULL_EN to add the registered almost-full flag (wafull) and its level logic.
module k_wctl_t2 #(
  parameter int unsigned addr_size    = 4,
  parameter int unsigned afull_thresh = 2
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 wput,
  input  logic [addr_size:0]   wrptr,
  output logic                 wen,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wptr,
  output logic                 wfull,
`ifdef K_WCTL_AFULL_EN
  output logic                 wafull,
`endif
  output logic                 wovf
);

  localparam int unsigned PtrW = addr_size + 1;

  // Elaboration-time parameter sanity checks.
  if (addr_size < 2) begin : g_chk_addr
    $error("k_wctl_t2: addr_size must be at least 2");
  end
  if (afull_thresh < 1 || afull_thresh >= (2 ** addr_size)) begin : g_chk_thresh
    $error("k_wctl_t2: afull_thresh out of range");
  end

  logic [addr_size:0] wbin;
  logic [addr_size:0] wbin_next;
  logic [addr_size:0] wgray_next;
  logic [addr_size:0] wq1_rptr;
  logic [addr_size:0] wq2_rptr;
  logic [addr_size:0] full_ptr;
  logic               accept;
  logic               wfull_next;
  logic               wovf_next;

  assign accept = wput & ~wfull;
  assign wen    = accept;
  assign waddr  = wbin[addr_size-1:0];

  always_comb begin
    wbin_next  = wbin + {{addr_size{1'b0}}, accept};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    full_ptr   = {~wq2_rptr[addr_size -: 2], wq2_rptr[addr_size-2:0]};
    wfull_next = (wgray_next == full_ptr);
    wovf_next  = wovf | (wput & wfull);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin     <= '0;
      wptr     <= '0;
      wq1_rptr <= '0;
      wq2_rptr <= '0;
      wfull    <= 1'b0;
      wovf     <= 1'b0;
    end else begin
      wbin     <= wbin_next;
      wptr     <= wgray_next;
      wq1_rptr <= wrptr;
      wq2_rptr <= wq1_rptr;
      wfull    <= wfull_next;
      wovf     <= wovf_next;
    end
  end

`ifdef K_WCTL_AFULL_EN
  localparam logic [addr_size:0] AfullLevel = PtrW'((2 ** addr_size) - afull_thresh);

  logic [addr_size:0] wrbin;
  logic [addr_size:0] wlevel;
  logic               wafull_next;

  // Gray to binary as a prefix XOR from the MSB down.
  function automatic logic [addr_size:0] gray2bin(input logic [addr_size:0] g);
    logic [addr_size:0] b;
    b = g;
    for (int s = 1; s < PtrW; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

  always_comb begin
    wrbin       = gray2bin(wq2_rptr);
    wlevel      = wbin_next - wrbin;
    wafull_next = (wlevel >= AfullLevel);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wafull <= 1'b0;
    end else begin
      wafull <= wafull_next;
    end
  end
`endif

endmodule

// File: tb/tb_k_wctl_t2.sv
// Bench for k_wctl_t2: directed scenarios plus random traffic checked against a count-based model.
module tb_k_wctl_t2;

  localparam int AW    = 4;
  localparam int Depth = 16;
  localparam int Laps  = 32;
  localparam int Thr   = 2;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          wput;
  logic [AW:0]   wrptr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          wovf;
`ifdef K_WCTL_AFULL_EN
  logic          wafull;
`endif

  k_wctl_t2 #(
    .addr_size    (AW),
    .afull_thresh (Thr)
  ) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .wput   (wput),
    .wrptr  (wrptr),
    .wen    (wen),
    .waddr  (waddr),
    .wptr   (wptr),
    .wfull  (wfull),
`ifdef K_WCTL_AFULL_EN
    .wafull (wafull),
`endif
    .wovf   (wovf)
  );

  always #5 wclk = ~wclk;

  int n_vec = 0;
  int n_err = 0;

  // Model: total writes accepted and reads done, as plain counts.
  int rd_cnt = 0;
  int m_tot  = 0;
  int m_s1   = 0;
  int m_s2   = 0;
  bit m_full = 0;
  bit m_afull = 0;
  bit m_ovf  = 0;

  function automatic logic [AW:0] gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int mod_laps(input int v);
    return ((v % Laps) + Laps) % Laps;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit put, input bit rst);
    int lvl;
    if (rst) begin
      m_tot = 0; m_s1 = 0; m_s2 = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      if (put && m_full) m_ovf = 1;
      if (put && !m_full) m_tot++;
      lvl     = mod_laps(m_tot - m_s2);
      m_full  = (lvl == Depth);
      m_afull = (lvl >= Depth - Thr);
      m_s2    = m_s1;
      m_s1    = rd_cnt;
    end
  endtask

  task automatic cycle(input bit put, input bit rst);
    @(negedge wclk);
    wput  = put;
    wrst  = rst;
    wrptr = gray(rd_cnt);
    #1;
    check("wen", {31'd0, wen}, {31'd0, put & ~m_full});
    @(posedge wclk);
    model_edge(put, rst);
    #1;
    check("wptr", {27'd0, wptr}, {27'd0, gray(m_tot)});
    check("waddr", {28'd0, waddr}, 32'(m_tot % Depth));
    check("wfull", {31'd0, wfull}, {31'd0, m_full});
    check("wovf", {31'd0, wovf}, {31'd0, m_ovf});
`ifdef K_WCTL_AFULL_EN
    check("wafull", {31'd0, wafull}, {31'd0, m_afull});
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int guard;
    wput = 0; wrst = 1; wrptr = '0;

    // Reset
    rd_cnt = 0;
    cycle(0, 1);
    cycle(0, 1);
    check("rst_wptr", {27'd0, wptr}, 32'd0);
    check("rst_wfull", {31'd0, wfull}, 32'd0);

    // Fill
    repeat (Depth) cycle(1, 0);
    check("fill_wptr", {27'd0, wptr}, 32'b11000);
    check("fill_wfull", {31'd0, wfull}, 32'd1);
    check("fill_wen", {31'd0, wen}, 32'd0);

    // Overflow
    repeat (3) cycle(1, 0);
    check("ovf_wptr", {27'd0, wptr}, 32'b11000);
    check("ovf_flag", {31'd0, wovf}, 32'd1);

    // Release and wrap
    rd_cnt = 1;
    cycle(0, 0);
    cycle(0, 0);
    check("rel_hold", {31'd0, wfull}, 32'd1);
    cycle(0, 0);
    check("rel_3rd", {31'd0, wfull}, 32'd0);
    check("rel_waddr", {28'd0, waddr}, 32'd0);
    cycle(1, 0);
    check("rel_wptr", {27'd0, wptr}, 32'b11001);
    check("rel_full", {31'd0, wfull}, 32'd1);
    guard = 0;
    while (m_tot < Laps && guard < 300) begin
      if (rd_cnt < m_tot && $urandom_range(0, 1) == 1) rd_cnt++;
      cycle(1, 0);
      guard++;
    end
    check("wrap_done", 32'(m_tot), 32'(Laps));
    check("wrap_wptr", {27'd0, wptr}, 32'd0);
    check("wrap_ovf", {31'd0, wovf}, 32'd1);

    // Reset mid-operation
    rd_cnt = 0;
    cycle(0, 1);
    repeat (7) cycle(1, 0);
    cycle(1, 1);
    check("mrst_wptr", {27'd0, wptr}, 32'd0);
    check("mrst_waddr", {28'd0, waddr}, 32'd0);
    cycle(1, 0);
    check("mrst_next", {27'd0, wptr}, 32'b00001);

    // Almost full
    rd_cnt = 0;
    cycle(0, 1);
    repeat (Depth - Thr) cycle(1, 0);
    check("af_full", {31'd0, wfull}, 32'd0);
`ifdef K_WCTL_AFULL_EN
    check("af_set", {31'd0, wafull}, 32'd1);
`endif
    rd_cnt = 1;
    repeat (2) cycle(0, 0);
`ifdef K_WCTL_AFULL_EN
    check("af_hold", {31'd0, wafull}, 32'd1);
`endif
    cycle(0, 0);
`ifdef K_WCTL_AFULL_EN
    check("af_clear", {31'd0, wafull}, 32'd0);
`endif

    // Random traffic
    rd_cnt = 0;
    cycle(0, 1);
    for (int i = 0; i < 500; i++) begin
      bit put;
      bit rst;
      rst = ($urandom_range(0, 149) == 0);
      put = ($urandom_range(0, 3) != 0);
      if (rst) rd_cnt = 0;
      else if (rd_cnt < m_tot && $urandom_range(0, 2) == 0) rd_cnt++;
      cycle(put, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
